bp_stats_collector: RTL
=======================

BP_STATS_COLLECTOR -- requirements
Module: bp_stats_collector

Interface
REQ-001 Parameter ADDR_WID, default 32, branch address width; SHALL match the predictor's address width.
REQ-002 Parameter CNT_WID, default 32, width of the cumulative counters.
REQ-003 Parameter PRED_LAT, default 1, cycles from b_valid to the matching prediction; legal range 1..4.
REQ-004 Parameter WINDOW, default 1024, branches per accuracy window; SHALL be a power of two of at least 4.
REQ-005 clk  in  1  sole clock; all state changes on its rising edge.
REQ-006 rst_n  in  1  reset, asynchronous and active-low.
REQ-007 b_valid  in  1  branch record presented to the predictor this cycle.
REQ-008 b_addr  in  ADDR_WID  branch address presented with b_valid.
REQ-009 b_taken  in  1  resolved outcome presented with b_valid.
REQ-010 prediction  in  1  predictor output, valid PRED_LAT cycles after b_valid.
REQ-011 clear  in  1  synchronous clear of all statistics.
REQ-012 snap_req  in  1  request a snapshot of the cumulative counters.
REQ-013 snap_valid  out  1  snapshot held on the snap_* outputs.
REQ-014 snap_ready  in  1  consumer accepts the snapshot.
REQ-015 snap_total, snap_mispred  out  CNT_WID each  snapshotted branch and misprediction counts.
REQ-016 win_done  out  1  one-cycle pulse when a window completes.
REQ-017 win_mispred  out  $clog2(WINDOW)+1  mispredictions in the last completed window.
REQ-018 last_mispred_addr  out  ADDR_WID  address of the most recent misprediction.
REQ-019 max_streak  out  16  longest run of consecutive mispredictions.

Function
REQ-020 b_valid, b_addr and b_taken SHALL be delayed PRED_LAT stages; a delayed valid is a "resolved branch" compared against prediction in that same cycle.
REQ-021 Resolved branch: total SHALL increment by one; if prediction != delayed b_taken, mispred SHALL increment and last_mispred_addr SHALL load the delayed b_addr.
REQ-022 total and mispred SHALL saturate at all-ones and not wrap.
REQ-023 Window counter SHALL count resolved branches modulo WINDOW; on the branch completing a window, win_done SHALL pulse in the next cycle.
REQ-024 With win_done, win_mispred SHALL load the completed window's count, including that final branch, and the window mispredict count SHALL restart from 0.
REQ-025 Snapshot FSM states:
  - IDLE --snap_req--> HOLD, capturing the current total/mispred, which exclude any branch resolving in the same cycle.
  - HOLD: snap_valid=1 and snap_* stable.
  - HOLD --snap_ready--> IDLE.
  - snap_req in HOLD SHALL be ignored.
REQ-026 clear SHALL zero the counters, window state, last_mispred_addr, max_streak and delay-line valids; a branch resolving in the clear cycle SHALL be discarded.
REQ-027 clear SHALL NOT abort HOLD; snap_req with clear in the same cycle SHALL capture pre-clear values.
REQ-028 win_done SHALL NOT pulse in the cycle after clear.

Reset
REQ-029 While rst_n=0, all outputs SHALL be 0, the FSM SHALL be IDLE and all delay-line valids 0; reset mid-HOLD drops the snapshot with no handshake.
REQ-030 Reset release SHALL take effect on the first rising clk edge with rst_n=1.

Configuration
REQ-031 Macro BP_STATS_STREAK_EN: when defined, the current streak increments per misprediction and clears on a correct prediction, saturating at 16'hFFFF; max_streak tracks its maximum.
REQ-032 When BP_STATS_STREAK_EN is undefined, no streak logic SHALL exist and max_streak SHALL be driven 0.

Structure
REQ-033 Package bp_stats_pkg SHALL hold the snapshot FSM state enum, the snapshot struct (total, mispred) and the max_streak width constant.
REQ-034 Sub-module bp_delay_line, a parameterized PRED_LAT-stage valid/data shift register with synchronous flush, SHALL implement REQ-020.

Verification
REQ-035 Reset, then 10 branches all predicted correctly, PRED_LAT=1 -> total=10, mispred=0, last_mispred_addr=0.
REQ-036 WINDOW=4, outcomes T,T,N,T with prediction always 1 -> one win_done pulse, win_mispred=1, last_mispred_addr=address of the N branch.
REQ-037 CNT_WID=4, 20 mispredicted branches -> snapshot reads total=15, mispred=15.
REQ-038 snap_req with snap_ready held 0 for 5 cycles while 3 branches resolve -> snap_* unchanged through HOLD; return to IDLE on snap_ready.
REQ-039 clear in the cycle a branch resolves, with snap_req in the same cycle -> snapshot holds pre-clear counts, counters are 0 next cycle, and the discarded branch is not counted.
REQ-040 BP_STATS_STREAK_EN defined, pattern M,M,M,C,M,M -> max_streak=3; macro undefined -> max_streak=0.

Source files
------------

// File: rtl/bp_stats_pkg.sv
// Shared types and constants for the branch-predictor statistics collector.
package bp_stats_pkg;

  localparam int STREAK_WID   = 16;
  // Snapshot fields are sized for the widest supported counter (CNT_WID <= 64).
  localparam int SNAP_MAX_WID = 64;

  typedef enum logic {
    SNAP_IDLE,
    SNAP_HOLD
  } snap_state_e;

  typedef struct packed {
    logic [SNAP_MAX_WID-1:0] total;
    logic [SNAP_MAX_WID-1:0] mispred;
  } snap_t;

endpackage

// File: rtl/bp_delay_line.sv
// LAT-stage valid/data shift register; flush_i synchronously drops every valid bit.
module bp_delay_line #(
  parameter int LAT = 1,
  parameter int DW  = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush_i,
  input  logic          valid_i,
  input  logic [DW-1:0] data_i,
  output logic          valid_o,
  output logic [DW-1:0] data_o
);

  logic [LAT-1:0] valid_q;
  logic [DW-1:0]  data_q [LAT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < LAT; i++) data_q[i] <= '0;
    end else begin
      valid_q[0] <= valid_i & ~flush_i;
      data_q[0]  <= data_i;
      for (int i = 1; i < LAT; i++) begin
        valid_q[i] <= valid_q[i-1] & ~flush_i;
        data_q[i]  <= data_q[i-1];
      end
    end
  end

  assign valid_o = valid_q[LAT-1];
  assign data_o  = data_q[LAT-1];

endmodule

// File: rtl/bp_stats_collector.sv
// Branch-predictor accuracy statistics: cumulative/windowed mispredict counts and snapshots.
// Optional misprediction streak tracking is enabled by defining BP_STATS_STREAK_EN.
module bp_stats_collector
  import bp_stats_pkg::*;
#(
  parameter int ADDR_WID = 32,
  parameter int CNT_WID  = 32,
  parameter int PRED_LAT = 1,
  parameter int WINDOW   = 1024
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       b_valid,
  input  logic [ADDR_WID-1:0]        b_addr,
  input  logic                       b_taken,
  input  logic                       prediction,
  input  logic                       clear,
  input  logic                       snap_req,
  output logic                       snap_valid,
  input  logic                       snap_ready,
  output logic [CNT_WID-1:0]         snap_total,
  output logic [CNT_WID-1:0]         snap_mispred,
  output logic                       win_done,
  output logic [$clog2(WINDOW):0]    win_mispred,
  output logic [ADDR_WID-1:0]        last_mispred_addr,
  output logic [STREAK_WID-1:0]      max_streak
);

  localparam int WIN_IDX = $clog2(WINDOW);
  localparam int WIN_CW  = WIN_IDX + 1;

  logic                res_valid;
  logic                res_taken;
  logic [ADDR_WID-1:0] res_addr;
  logic                res_mis;

  bp_delay_line #(
    .LAT (PRED_LAT),
    .DW  (ADDR_WID + 1)
  ) u_delay (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (clear),
    .valid_i (b_valid),
    .data_i  ({b_taken, b_addr}),
    .valid_o (res_valid),
    .data_o  ({res_taken, res_addr})
  );

  assign res_mis = (prediction != res_taken);

  logic [CNT_WID-1:0]  total_q, total_d, mispred_q, mispred_d;
  logic [WIN_IDX-1:0]  win_cnt_q, win_cnt_d, win_mis_q, win_mis_d;
  logic [WIN_CW-1:0]   win_mispred_q, win_mispred_d;
  logic                win_done_q, win_done_d;
  logic [ADDR_WID-1:0] last_addr_q, last_addr_d;

  // Clear outranks a resolving branch, so that branch is simply never counted.
  always_comb begin
    total_d       = total_q;
    mispred_d     = mispred_q;
    win_cnt_d     = win_cnt_q;
    win_mis_d     = win_mis_q;
    win_done_d    = 1'b0;
    win_mispred_d = win_mispred_q;
    last_addr_d   = last_addr_q;
    if (clear) begin
      total_d       = '0;
      mispred_d     = '0;
      win_cnt_d     = '0;
      win_mis_d     = '0;
      win_mispred_d = '0;
      last_addr_d   = '0;
    end else if (res_valid) begin
      if (total_q != '1) total_d = total_q + 1'b1;
      if (res_mis) begin
        if (mispred_q != '1) mispred_d = mispred_q + 1'b1;
        last_addr_d = res_addr;
      end
      win_cnt_d = win_cnt_q + 1'b1;
      if (win_cnt_q == WIN_IDX'(WINDOW - 1)) begin
        win_done_d    = 1'b1;
        win_mispred_d = WIN_CW'(win_mis_q) + WIN_CW'(res_mis);
        win_mis_d     = '0;
      end else begin
        win_mis_d = win_mis_q + WIN_IDX'(res_mis);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      total_q       <= '0;
      mispred_q     <= '0;
      win_cnt_q     <= '0;
      win_mis_q     <= '0;
      win_done_q    <= 1'b0;
      win_mispred_q <= '0;
      last_addr_q   <= '0;
    end else begin
      total_q       <= total_d;
      mispred_q     <= mispred_d;
      win_cnt_q     <= win_cnt_d;
      win_mis_q     <= win_mis_d;
      win_done_q    <= win_done_d;
      win_mispred_q <= win_mispred_d;
      last_addr_q   <= last_addr_d;
    end
  end

  snap_state_e state_q;
  logic        snap_valid_q;
  snap_t       snap_q;

  // Capture uses the registered counts, so a branch resolving in the request cycle is excluded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= SNAP_IDLE;
      snap_valid_q <= 1'b0;
      snap_q       <= '0;
    end else begin
      case (state_q)
        SNAP_IDLE: begin
          if (snap_req) begin
            state_q        <= SNAP_HOLD;
            snap_valid_q   <= 1'b1;
            snap_q.total   <= SNAP_MAX_WID'(total_q);
            snap_q.mispred <= SNAP_MAX_WID'(mispred_q);
          end
        end
        SNAP_HOLD: begin
          if (snap_ready) begin
            state_q      <= SNAP_IDLE;
            snap_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q      <= SNAP_IDLE;
          snap_valid_q <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (((snap_q.total >> CNT_WID) == '0) && ((snap_q.mispred >> CNT_WID) == '0));
    end
  end

`ifdef BP_STATS_STREAK_EN
  logic [STREAK_WID-1:0] streak_q, streak_d, max_streak_q, max_streak_d;

  always_comb begin
    streak_d     = streak_q;
    max_streak_d = max_streak_q;
    if (clear) begin
      streak_d     = '0;
      max_streak_d = '0;
    end else if (res_valid) begin
      if (res_mis) begin
        if (streak_q != '1) streak_d = streak_q + 1'b1;
      end else begin
        streak_d = '0;
      end
      if (streak_d > max_streak_q) max_streak_d = streak_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      streak_q     <= '0;
      max_streak_q <= '0;
    end else begin
      streak_q     <= streak_d;
      max_streak_q <= max_streak_d;
    end
  end

  assign max_streak = max_streak_q;
`else
  assign max_streak = '0;
`endif

  assign snap_valid        = snap_valid_q;
  assign snap_total        = snap_q.total[CNT_WID-1:0];
  assign snap_mispred      = snap_q.mispred[CNT_WID-1:0];
  assign win_done          = win_done_q;
  assign win_mispred       = win_mispred_q;
  assign last_mispred_addr = last_addr_q;

endmodule
